// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage: one access at a time, fixed wait states,
// word storage mapped at BASE_ADDR with out-of-range flagging.
module data_mem_responder #(
  parameter int          DEPTH_WORDS = 64,
  parameter int          WAIT_CYCLES = 4,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] address,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        ready,
  output logic        addr_err
);

  localparam int          IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int          CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [31:0] SPAN  = 32'(4 * DEPTH_WORDS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  logic [1:0]       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  req_t             req_q, req_sel;
  logic             req_any;
  logic             enter_done;
  logic [31:0]      off;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic             commit;
  logic [31:0]      mem [DEPTH_WORDS];

  assign req_any = mem_r_en | mem_w_en;

  // In IDLE the live inputs are decoded so WAIT_CYCLES=1 can complete straight from acceptance.
  always_comb begin
    req_sel = req_q;
    if (state == IDLE) begin
      req_sel.wr   = mem_w_en;
      req_sel.addr = address;
      req_sel.data = wr_data;
    end
  end

  assign off      = req_sel.addr - BASE_ADDR;
  assign in_range = (off < SPAN);
  assign idx      = off[IDX_W+1:2];
  assign commit   = (state == DONE) && req_q.wr && in_range;

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    enter_done = 1'b0;
    case (state)
      IDLE: begin
        if (req_any) begin
          cnt_d = CNT_W'(WAIT_CYCLES - 1);
          if (WAIT_CYCLES == 1) begin
            state_d    = DONE;
            enter_done = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (!req_any) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state_d    = DONE;
            enter_done = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Only state and enables reach ready; address/data never do.
  always_comb begin
    case (state)
      IDLE:    ready = ~req_any;
      BUSY:    ready = 1'b0;
      DONE:    ready = 1'b1;
      default: ready = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      req_q    <= '0;
      rd_data  <= '0;
      addr_err <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      addr_err <= enter_done && !in_range;
      if (state == IDLE && req_any)
        req_q <= req_sel;
      if (enter_done && !req_sel.wr)
        rd_data <= in_range ? mem[idx] : 32'd0;
    end
  end

  // Storage survives reset; a reset already forces state out of DONE, blocking the commit.
  always_ff @(posedge clk) begin
    if (commit)
      mem[idx] <= req_q.data;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder: transaction-level model for a 4-wait-state
// instance and a 1-wait-state instance, checked every cycle plus literal pins.
module tb_data_mem_responder;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'd1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r_en [2];
  logic        w_en [2];
  logic [31:0] addr [2];
  logic [31:0] wdat [2];
  logic [31:0] rdat [2];
  logic        rdy  [2];
  logic        aerr [2];

  logic [31:0] mdl_mem [2][DEPTH];
  logic [31:0] mdl_rd   [2];
  logic        want_rdy [2];
  logic        want_err [2];
  logic [31:0] want_rd  [2];
  bit          chk_en = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(4), .BASE_ADDR(BASE)) dut0 (
    .clk(clk), .rst(rst), .mem_r_en(r_en[0]), .mem_w_en(w_en[0]), .address(addr[0]),
    .wr_data(wdat[0]), .rd_data(rdat[0]), .ready(rdy[0]), .addr_err(aerr[0]));

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1), .BASE_ADDR(BASE)) dut1 (
    .clk(clk), .rst(rst), .mem_r_en(r_en[1]), .mem_w_en(w_en[1]), .address(addr[1]),
    .wr_data(wdat[1]), .rd_data(rdat[1]), .ready(rdy[1]), .addr_err(aerr[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("dut%0d_ready", k), {31'd0, rdy[k]},  {31'd0, want_rdy[k]});
        check($sformatf("dut%0d_err", k),   {31'd0, aerr[k]}, {31'd0, want_err[k]});
        check($sformatf("dut%0d_rd", k),    rdat[k],          want_rd[k]);
      end
    end
  end

  task automatic set_idle(input int k);
    w_en[k] = 1'b0; r_en[k] = 1'b0;
    want_rdy[k] = 1'b1; want_err[k] = 1'b0; want_rd[k] = mdl_rd[k];
  endtask

  // Entered and left at posedge+1. Cycle 0 presents the request; cycle w is completion.
  task automatic access(input int k, input logic we, input logic re,
                        input logic [31:0] a, input logic [31:0] d,
                        input int abort_c, input int rst_c, input int jit,
                        output int lat, output logic err_seen, output logic [31:0] rd_done);
    int w; logic inr; int idx; logic [1:0] sel;
    w   = (k == 0) ? 4 : 1;
    inr = (a >= BASE) && (a < BASE + 32'(4 * DEPTH));
    idx = int'(((a - BASE) >> 2) & 32'(DEPTH - 1));
    lat = 0; err_seen = 1'b0; rd_done = '0;
    w_en[k] = we; r_en[k] = re; addr[k] = a; wdat[k] = d;
    for (int c = 0; c <= w; c++) begin
      if (c > 0 && jit == 1) begin
        sel = (c < w) ? 2'($urandom_range(1, 3)) : 2'($urandom_range(0, 3));
        w_en[k] = sel[0]; r_en[k] = sel[1]; addr[k] = $urandom; wdat[k] = $urandom;
      end else if (c == 2 && jit == 2) begin
        addr[k] = a + 32'd4; wdat[k] = 32'd0;
      end
      if (c == w) begin
        want_rdy[k] = 1'b1; want_err[k] = !inr;
        if (!we) mdl_rd[k] = inr ? mdl_mem[k][idx] : 32'd0;
        want_rd[k] = mdl_rd[k];
      end else begin
        want_rdy[k] = 1'b0; want_err[k] = 1'b0;
      end
      if (c == abort_c) begin
        w_en[k] = 1'b0; r_en[k] = 1'b0;
      end
      if (c == rst_c) begin
        #1 rst = 1'b0;
        w_en[k] = 1'b0; r_en[k] = 1'b0;
        for (int j = 0; j < 2; j++) begin
          mdl_rd[j] = 32'd0;
          set_idle(j);
        end
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #1;
        return;
      end
      @(negedge clk);
      if (!rdy[k]) lat++;
      if (c == w) begin err_seen = aerr[k]; rd_done = rdat[k]; end
      @(posedge clk); #1;
      if (c == abort_c) begin
        set_idle(k);
        return;
      end
    end
    if (we && inr) mdl_mem[k][idx] = d;
    set_idle(k);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int lat; logic es; logic [31:0] rdd;
    for (int k = 0; k < 2; k++) begin
      r_en[k] = 1'b0; w_en[k] = 1'b0; addr[k] = '0; wdat[k] = '0;
      mdl_rd[k] = '0; set_idle(k);
    end
    #2 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_ready", {31'd0, rdy[0]}, 32'd1);
    check("reset_rd", rdat[0], 32'd0);
    check("reset_err", {31'd0, aerr[0]}, 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    for (int k = 0; k < 2; k++)
      for (int i = 0; i < DEPTH; i++)
        access(k, 1'b1, 1'b0, BASE + 32'(4 * i), 32'hC0DE0000 | 32'(i), -1, -1, 0, lat, es, rdd);

    access(0, 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, -1, -1, 0, lat, es, rdd);
    check("t1_wr_lat", 32'(lat), 32'd4);
    access(0, 1'b0, 1'b1, 32'd1024, 32'd0, -1, -1, 0, lat, es, rdd);
    check("t1_rd_lat", 32'(lat), 32'd4);
    check("t1_rd_data", rdd, 32'hDEADBEEF);

    access(0, 1'b1, 1'b0, 32'd1276, 32'h12345678, -1, -1, 0, lat, es, rdd);
    access(0, 1'b0, 1'b1, 32'd1276, 32'd0, -1, -1, 0, lat, es, rdd);
    check("t2_last_word", rdd, 32'h12345678);
    access(0, 1'b0, 1'b1, 32'd1280, 32'd0, -1, -1, 0, lat, es, rdd);
    check("t2_1280_rd", rdd, 32'd0);
    check("t2_1280_err", {31'd0, es}, 32'd1);
    access(0, 1'b0, 1'b1, 32'd1020, 32'd0, -1, -1, 0, lat, es, rdd);
    check("t2_1020_err", {31'd0, es}, 32'd1);

    access(0, 1'b1, 1'b0, 32'd1028, 32'hAAAA5555, -1, -1, 2, lat, es, rdd);
    access(0, 1'b0, 1'b1, 32'd1028, 32'd0, -1, -1, 0, lat, es, rdd);
    check("t3_word1", rdd, 32'hAAAA5555);
    access(0, 1'b0, 1'b1, 32'd1032, 32'd0, -1, -1, 0, lat, es, rdd);
    check("t3_word2", rdd, 32'hC0DE0002);

    access(0, 1'b1, 1'b0, 32'd1036, 32'd1, 2, -1, 0, lat, es, rdd);
    check("t4_abort_lat", 32'(lat), 32'd3);
    access(0, 1'b0, 1'b1, 32'd1036, 32'd0, -1, -1, 0, lat, es, rdd);
    check("t4_word3", rdd, 32'hC0DE0003);

    access(0, 1'b1, 1'b0, 32'd1040, 32'hFFFFFFFF, -1, 2, 0, lat, es, rdd);
    check("t5_rd_reset", rdat[0], 32'd0);
    access(0, 1'b0, 1'b1, 32'd1040, 32'd0, -1, -1, 0, lat, es, rdd);
    check("t5_lat", 32'(lat), 32'd4);
    check("t5_word4", rdd, 32'hC0DE0004);

    access(0, 1'b1, 1'b1, 32'd1044, 32'h55, -1, -1, 0, lat, es, rdd);
    check("t6_both_rd_hold", rdd, 32'hC0DE0004);
    access(0, 1'b0, 1'b1, 32'd1044, 32'd0, -1, -1, 0, lat, es, rdd);
    check("t6_both_commit", rdd, 32'h55);
    access(1, 1'b1, 1'b0, 32'd1024, 32'h77, -1, -1, 0, lat, es, rdd);
    check("t6_w1_wr_lat", 32'(lat), 32'd1);
    access(1, 1'b0, 1'b1, 32'd1024, 32'd0, -1, -1, 0, lat, es, rdd);
    check("t6_w1_rd_lat", 32'(lat), 32'd1);
    check("t6_w1_rd", rdd, 32'h77);

    for (int n = 0; n < 300; n++) begin
      int k; int ab; logic we; logic re; logic [31:0] a;
      k = int'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        we = 1'b0; re = 1'b1;
        case ($urandom_range(0, 2))
          0:       a = 32'd1280 + $urandom_range(0, 100000);
          1:       a = $urandom_range(0, 1023);
          default: a = $urandom | 32'h80000000;
        endcase
      end else begin
        a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + $urandom_range(0, 3);
        case ($urandom_range(0, 2))
          0:       begin we = 1'b0; re = 1'b1; end
          1:       begin we = 1'b1; re = 1'b0; end
          default: begin we = 1'b1; re = 1'b1; end
        endcase
      end
      ab = (k == 0 && $urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : -1;
      access(k, we, re, a, $urandom, ab, -1, 1, lat, es, rdd);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
